// File: rtl/demapper_check.sv
// -----------------------------------------------------------------------------
// demapper_check
//
// Purpose:
//   Frame demapper with CRC gating. Hunts for the frame alignment sequence
//   F6 F6 28 28, collects PYLD_LEN payload bytes into an internal buffer while
//   running a CRC-8 (poly 0x07, init 00, MSB first), checks the trailing CRC
//   byte and, when allowed, drains the buffered payload to the client.
//   With ARQ enabled a good frame pulses o_ack and is released; a bad frame
//   pulses o_nack and is discarded. With ARQ disabled every frame is released
//   and neither pulse is produced.
//
// Parameters:
//   PYLD_LEN            payload bytes per frame (2..256)
//
// Optional feature:
//   DEMAP_CRC_ERR_CNT_EN  when defined, o_crc_err_cnt is a saturating count of
//                         o_nack pulses; when undefined it is tied to 00.
//
// Ports:
//   i_clk               clock, rising edge active
//   i_rst_n             asynchronous active-low reset
//   i_frame_data        received frame byte
//   i_frame_data_valid  frame byte qualifier
//   o_frame_data_ready  block accepts a frame byte (low while draining)
//   o_pyld_data         verified payload byte
//   o_pyld_data_valid   payload byte qualifier
//   i_pyld_data_ready   client accepts a payload byte
//   i_arq_en            1 = CRC gating with ACK/NACK, 0 = pass-through
//   o_ack               one-cycle pulse, frame with good CRC
//   o_nack              one-cycle pulse, frame with bad CRC
//   o_crc_val           CRC computed over the last completed frame
//   o_crc_err_cnt       bad-CRC frame count (see optional feature)
// -----------------------------------------------------------------------------
module demapper_check #(
    parameter int PYLD_LEN = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [7:0] i_frame_data,
    input  logic       i_frame_data_valid,
    output logic       o_frame_data_ready,
    output logic [7:0] o_pyld_data,
    output logic       o_pyld_data_valid,
    input  logic       i_pyld_data_ready,
    input  logic       i_arq_en,
    output logic       o_ack,
    output logic       o_nack,
    output logic [7:0] o_crc_val,
    output logic [7:0] o_crc_err_cnt
);

    localparam int               PTR_W    = (PYLD_LEN > 1) ? $clog2(PYLD_LEN) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(PYLD_LEN - 1);
    localparam logic [7:0]       FAS_A    = 8'hF6;   // FAS bytes 0 and 1
    localparam logic [7:0]       FAS_B    = 8'h28;   // FAS bytes 2 and 3

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_PYLD  = 2'd1,
        ST_CRC   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // One byte of CRC-8, polynomial x^8+x^2+x+1, MSB first, no reflection.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc,
                                             input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    state_e           state_q,   state_d;
    logic [1:0]       fas_idx_q, fas_idx_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [7:0]       crc_q,     crc_d;
    logic [7:0]       crc_val_q, crc_val_d;
    logic             ack_q,     ack_d;
    logic             nack_q,    nack_d;
    logic             mem_we;
    logic [7:0]       pyld_mem_q [PYLD_LEN];

    logic             frame_acc;
    logic             pyld_acc;
    logic [7:0]       fas_exp;

    assign o_frame_data_ready = (state_q != ST_DRAIN);
    assign o_pyld_data_valid  = (state_q == ST_DRAIN);
    // The read pointer only moves on a transfer, so data holds under backpressure.
    assign o_pyld_data        = pyld_mem_q[rd_ptr_q];
    assign o_ack              = ack_q;
    assign o_nack             = nack_q;
    assign o_crc_val          = crc_val_q;

    assign frame_acc = i_frame_data_valid && o_frame_data_ready;
    assign pyld_acc  = o_pyld_data_valid && i_pyld_data_ready;
    assign fas_exp   = fas_idx_q[1] ? FAS_B : FAS_A;

    // -------------------------------------------------------------------------
    // Next-state / datapath control
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        fas_idx_d = fas_idx_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        crc_d     = crc_q;
        crc_val_d = crc_val_q;
        ack_d     = 1'b0;
        nack_d    = 1'b0;
        mem_we    = 1'b0;

        unique case (state_q)
            ST_HUNT: begin
                if (frame_acc) begin
                    if (i_frame_data == fas_exp) begin
                        if (fas_idx_q == 2'd3) begin
                            fas_idx_d = 2'd0;
                            state_d   = ST_PYLD;
                        end else begin
                            fas_idx_d = fas_idx_q + 2'd1;
                        end
                    end else if (i_frame_data == FAS_A) begin
                        // An F6 arriving where 28 was expected after F6 F6
                        // still leaves F6 F6 as a valid partial match; after
                        // F6 F6 28 only the new F6 counts.
                        fas_idx_d = (fas_idx_q == 2'd2) ? 2'd2 : 2'd1;
                    end else begin
                        fas_idx_d = 2'd0;
                    end
                end
            end

            ST_PYLD: begin
                if (frame_acc) begin
                    mem_we = 1'b1;
                    crc_d  = crc8_byte(crc_q, i_frame_data);
                    if (wr_ptr_q == LAST_IDX) begin
                        wr_ptr_d = '0;
                        state_d  = ST_CRC;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end
            end

            ST_CRC: begin
                if (frame_acc) begin
                    crc_val_d = crc_q;
                    // i_arq_en only matters here, so mid-frame changes are ignored.
                    if (!i_arq_en) begin
                        state_d = ST_DRAIN;
                    end else if (i_frame_data == crc_q) begin
                        ack_d   = 1'b1;
                        state_d = ST_DRAIN;
                    end else begin
                        // Bad frame: the buffer is simply never read out.
                        nack_d    = 1'b1;
                        crc_d     = 8'h00;
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                        fas_idx_d = 2'd0;
                        state_d   = ST_HUNT;
                    end
                end
            end

            ST_DRAIN: begin
                if (pyld_acc) begin
                    if (rd_ptr_q == LAST_IDX) begin
                        rd_ptr_d  = '0;
                        wr_ptr_d  = '0;
                        fas_idx_d = 2'd0;
                        crc_d     = 8'h00;
                        state_d   = ST_HUNT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_HUNT;
        endcase
    end

    // -------------------------------------------------------------------------
    // State and control registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_HUNT;
            fas_idx_q <= 2'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            crc_q     <= 8'h00;
            crc_val_q <= 8'h00;
            ack_q     <= 1'b0;
            nack_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            fas_idx_q <= fas_idx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            crc_q     <= crc_d;
            crc_val_q <= crc_val_d;
            ack_q     <= ack_d;
            nack_q    <= nack_d;
        end
    end

    // -------------------------------------------------------------------------
    // Payload buffer
    // -------------------------------------------------------------------------
    // NOTE: the buffer has no reset; stale contents are harmless because reset
    // returns to HUNT and a new frame overwrites every entry before DRAIN.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            pyld_mem_q[wr_ptr_q] <= i_frame_data;
        end
    end

    // -------------------------------------------------------------------------
    // Bad-CRC frame counter
    // -------------------------------------------------------------------------
`ifdef DEMAP_CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (nack_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign o_crc_err_cnt = err_cnt_q;
`else
    assign o_crc_err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_demapper_check.sv
// -----------------------------------------------------------------------------
// tb_demapper_check
//
// Directed plus randomized bench for demapper_check (PYLD_LEN = 4). A stream
// level reference model (sliding-window FAS search, bit-serial CRC, queue of
// expected payload) predicts ack/nack, o_crc_val, o_crc_err_cnt and the
// delivered bytes. Inputs change 1 ns after the rising edge; outputs are
// sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_demapper_check;

    localparam int PL = 4;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic [7:0] i_frame_data;
    logic       i_frame_data_valid;
    logic       o_frame_data_ready;
    logic [7:0] o_pyld_data;
    logic       o_pyld_data_valid;
    logic       i_pyld_data_ready;
    logic       i_arq_en;
    logic       o_ack;
    logic       o_nack;
    logic [7:0] o_crc_val;
    logic [7:0] o_crc_err_cnt;

    demapper_check #(.PYLD_LEN(PL)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_frame_data       (i_frame_data),
        .i_frame_data_valid (i_frame_data_valid),
        .o_frame_data_ready (o_frame_data_ready),
        .o_pyld_data        (o_pyld_data),
        .o_pyld_data_valid  (o_pyld_data_valid),
        .i_pyld_data_ready  (i_pyld_data_ready),
        .i_arq_en           (i_arq_en),
        .o_ack              (o_ack),
        .o_nack             (o_nack),
        .o_crc_val          (o_crc_val),
        .o_crc_err_cnt      (o_crc_err_cnt)
    );

    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;

    // Output monitor state
    int         rdy_mode  = 0;   // 0: always ready, 1: toggle, 2: random
    logic [7:0] got_q [$];
    int         ack_seen  = 0;
    int         nack_seen = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    // Reference model state
    int         m_mode = 0;      // 0: searching FAS, 1: payload, 2: CRC byte
    logic [31:0] m_win = 32'h0;
    logic [7:0] m_pay [$];
    logic [7:0] m_exp_q [$];
    logic       m_exp_ack   = 1'b0;
    logic       m_exp_nack  = 1'b0;
    logic       m_exp_drain = 1'b0;
    logic [7:0] m_exp_crc   = 8'h00;
    logic [7:0] m_exp_err   = 8'h00;
    int         m_ack_total  = 0;
    int         m_nack_total = 0;

    logic [7:0] pre_q [$];
    logic [7:0] pay_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // CRC-8 poly 0x07 computed one message bit at a time.
    function automatic logic [7:0] ref_crc(input logic [7:0] p [$]);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        foreach (p[i]) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[7] ^ p[i][k];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] rand_junk();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == 8'hF6 || b == 8'h28);
        return b;
    endfunction

    task automatic model_reset();
        m_mode    = 0;
        m_win     = 32'h0;
        m_pay.delete();
        m_exp_crc = 8'h00;
        m_exp_err = 8'h00;
    endtask

    // Called once per byte the DUT accepts, with the i_arq_en of that cycle.
    task automatic model_byte(input logic [7:0] b);
        logic [7:0] c;
        case (m_mode)
            0: begin
                m_win = {m_win[23:0], b};
                if (m_win == 32'hF6F62828) begin
                    m_mode = 1;
                    m_win  = 32'h0;
                    m_pay.delete();
                end
            end
            1: begin
                m_pay.push_back(b);
                if (m_pay.size() == PL) m_mode = 2;
            end
            default: begin
                c          = ref_crc(m_pay);
                m_exp_crc  = c;
                m_exp_ack  = 1'b0;
                m_exp_nack = 1'b0;
                if (!i_arq_en || b == c) begin
                    m_exp_drain = 1'b1;
                    foreach (m_pay[i]) m_exp_q.push_back(m_pay[i]);
                    if (i_arq_en) begin
                        m_exp_ack = 1'b1;
                        m_ack_total++;
                    end
                end else begin
                    m_exp_drain = 1'b0;
                    m_exp_nack  = 1'b1;
                    m_nack_total++;
`ifdef DEMAP_CRC_ERR_CNT_EN
                    if (m_exp_err != 8'hFF) m_exp_err = m_exp_err + 8'd1;
`endif
                end
                m_mode = 0;
            end
        endcase
    endtask

    // Entered and left 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        i_frame_data       = b;
        i_frame_data_valid = 1'b1;
        while (!ok && n < 200) begin
            @(negedge i_clk);
            ok = o_frame_data_ready;
            tick();
            n++;
        end
        i_frame_data_valid = 1'b0;
        check("frame_ready_wait", ok, 1'b1);
        if (ok) model_byte(b);
        if (gap) repeat ($urandom_range(0, 2)) tick();
    endtask

    task automatic compare_output();
        check("out_count", got_q.size(), m_exp_q.size());
        while (got_q.size() > 0 && m_exp_q.size() > 0) begin
            check("out_byte", got_q.pop_front(), m_exp_q.pop_front());
        end
        got_q.delete();
        m_exp_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] pre [$], input logic [7:0] pay [$],
                              input logic [7:0] crc_xor, input logic arq_final,
                              input bit jitter);
        int n;
        foreach (pre[i]) send_byte(pre[i], jitter);
        send_byte(8'hF6, jitter);
        send_byte(8'hF6, jitter);
        send_byte(8'h28, jitter);
        send_byte(8'h28, jitter);
        foreach (pay[i]) begin
            if (jitter) i_arq_en = 1'($urandom_range(0, 1));
            send_byte(pay[i], jitter);
        end
        i_arq_en = arq_final;
        send_byte(ref_crc(pay) ^ crc_xor, 1'b0);
        // First cycle after the CRC byte was accepted
        @(negedge i_clk);
        check("ack_pulse",      o_ack,              m_exp_ack);
        check("nack_pulse",     o_nack,             m_exp_nack);
        check("crc_val",        o_crc_val,          m_exp_crc);
        check("err_cnt",        o_crc_err_cnt,      m_exp_err);
        check("pyld_valid_lat", o_pyld_data_valid,  m_exp_drain);
        check("ready_in_drain", o_frame_data_ready, !m_exp_drain);
        @(negedge i_clk);
        check("ack_one_cycle",  o_ack,  1'b0);
        check("nack_one_cycle", o_nack, 1'b0);
        n = 0;
        while (!o_frame_data_ready && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        check("drain_done", o_frame_data_ready, 1'b1);
        compare_output();
        tick();
    endtask

    task automatic check_reset_outputs();
        check("rst_pyld_valid", o_pyld_data_valid, 1'b0);
        check("rst_ack",        o_ack,             1'b0);
        check("rst_nack",       o_nack,            1'b0);
        check("rst_crc_val",    o_crc_val,         8'h00);
        check("rst_err_cnt",    o_crc_err_cnt,     8'h00);
    endtask

    // Client-side ready pattern
    initial begin
        i_pyld_data_ready = 1'b1;
        forever begin
            tick();
            case (rdy_mode)
                1:       i_pyld_data_ready = ~i_pyld_data_ready;
                2:       i_pyld_data_ready = 1'($urandom_range(0, 1));
                default: i_pyld_data_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: transfers, pulse counts, hold-under-backpressure
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", o_pyld_data_valid, 1'b1);
                check("hold_data",  o_pyld_data,       prev_data);
            end
            if (o_pyld_data_valid) check("ready_low_drain", o_frame_data_ready, 1'b0);
            if (o_pyld_data_valid && i_pyld_data_ready) got_q.push_back(o_pyld_data);
            if (o_ack)  ack_seen++;
            if (o_nack) nack_seen++;
            prev_stall = o_pyld_data_valid && !i_pyld_data_ready;
            prev_data  = o_pyld_data;
        end
    end

    initial begin
        i_rst_n            = 1'b0;
        i_frame_data       = 8'h00;
        i_frame_data_valid = 1'b0;
        i_arq_en           = 1'b1;
        model_reset();

        // Reset state
        repeat (3) tick();
        @(negedge i_clk);
        check_reset_outputs();
        tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", o_frame_data_ready, 1'b1);
        tick();

        // Good frame, ARQ on
        pre_q.delete();
        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(pre_q, pay_q, 8'h00, 1'b1, 1'b0);

        // Same payload, CRC corrupted, ARQ on
        send_frame(pre_q, pay_q, 8'h01, 1'b1, 1'b0);

        // False sync: F6 F6 F6 28 28 then the good frame
        pre_q = '{8'hF6};
        send_frame(pre_q, pay_q, 8'h00, 1'b1, 1'b0);

        // Backpressure: client ready toggles every cycle
        rdy_mode = 1;
        pre_q.delete();
        send_frame(pre_q, pay_q, 8'h00, 1'b1, 1'b0);
        rdy_mode = 0;

        // Reset after payload byte 2, then a bad-CRC frame with ARQ off
        send_byte(8'hF6, 1'b0);
        send_byte(8'hF6, 1'b0);
        send_byte(8'h28, 1'b0);
        send_byte(8'h28, 1'b0);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h5A, 1'b0);
        i_rst_n = 1'b0;
        model_reset();
        @(negedge i_clk);
        check_reset_outputs();
        tick();
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst2", o_frame_data_ready, 1'b1);
        tick();
        pay_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(pre_q, pay_q, 8'h3C, 1'b0, 1'b0);

        // Randomized frames: junk, payload, CRC error, ARQ, client ready
        for (int f = 0; f < 40; f++) begin
            pre_q.delete();
            pay_q.delete();
            repeat ($urandom_range(0, 3)) pre_q.push_back(rand_junk());
            for (int k = 0; k < PL; k++) pay_q.push_back(8'($urandom_range(0, 255)));
            rdy_mode = $urandom_range(0, 2);
            send_frame(pre_q, pay_q,
                       ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'h00,
                       1'($urandom_range(0, 1)), 1'b1);
        end
        rdy_mode = 0;

        // Enough bad frames to reach counter saturation
        pre_q.delete();
        for (int f = 0; f < 260; f++) begin
            pay_q.delete();
            for (int k = 0; k < PL; k++) pay_q.push_back(8'($urandom_range(0, 255)));
            send_frame(pre_q, pay_q, 8'h80, 1'b1, 1'b0);
        end
        check("err_cnt_final", o_crc_err_cnt, m_exp_err);

        // Totals across the whole run
        check("ack_total",  ack_seen,  m_ack_total);
        check("nack_total", nack_seen, m_nack_total);
        check("no_stray_output", got_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
